// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the Uart8 receiver: edge-detects rxDone/rxErr,
// queues good bytes in a first-word-fall-through FIFO, tracks overrun and frame errors.
module uart_rx_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  rxDone,
  input  logic                  rxErr,
  input  logic [7:0]            rxByte,
  output logic [7:0]            outByte,
  output logic                  outValid,
  input  logic                  outReady,
  input  logic                  flush,
  input  logic                  clrOverrun,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  overrun,
  output logic [ERR_WIDTH-1:0]  errCount
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [7:0]            r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_rdPtr;
  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_doneQ;
  logic                  r_errQ;
  logic                  r_overrun;
  logic [ERR_WIDTH-1:0]  r_errCount;

  logic w_doneRise;
  logic w_errRise;
  logic w_pushReq;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_doneRise = rxDone & ~r_doneQ;
  assign w_errRise  = rxErr & ~r_errQ;
  assign w_pushReq  = w_doneRise & ~rxErr;
  assign w_full     = (r_count == LP_DEPTH);
  assign w_pop      = (r_count != '0) & outReady & ~flush;
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign w_push     = w_pushReq & ~flush & (~w_full | w_pop);
  assign w_drop     = w_pushReq & ~flush & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= rxByte;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_doneQ    <= 1'b1;
      r_errQ     <= 1'b1;
      r_overrun  <= 1'b0;
      r_errCount <= '0;
    end else begin
      r_doneQ <= rxDone;
      r_errQ  <= rxErr;
      if (flush) begin
        r_rdPtr <= '0;
        r_wrPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wrPtr <= r_wrPtr + ADDR_WIDTH'(1);
        if (w_pop)  r_rdPtr <= r_rdPtr + ADDR_WIDTH'(1);
        if (w_push && !w_pop)      r_count <= r_count + (ADDR_WIDTH+1)'(1);
        else if (w_pop && !w_push) r_count <= r_count - (ADDR_WIDTH+1)'(1);
      end
      if (w_drop)          r_overrun <= 1'b1;
      else if (clrOverrun) r_overrun <= 1'b0;
      if (w_errRise && r_errCount != '1) r_errCount <= r_errCount + ERR_WIDTH'(1);
    end
  end

  assign outByte  = r_mem[r_rdPtr];
  assign outValid = (r_count != '0);
  assign count    = r_count;
  assign full     = w_full;
  assign overrun  = r_overrun;
  assign errCount = r_errCount;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: push/pop, full/overrun, wrap, error counter,
// reset-edge masking, flush and asynchronous reset.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rstN;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxByte;
  logic [7:0] outByte;
  logic       outValid;
  logic       outReady;
  logic       flush;
  logic       clrOverrun;
  logic [4:0] count;
  logic       full;
  logic       overrun;
  logic [7:0] errCount;

  int unsigned n_checks;
  int unsigned n_errors;

  uart_rx_fifo #(.ADDR_WIDTH(4), .ERR_WIDTH(8)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .rxDone     (rxDone),
    .rxErr      (rxErr),
    .rxByte     (rxByte),
    .outByte    (outByte),
    .outValid   (outValid),
    .outReady   (outReady),
    .flush      (flush),
    .clrOverrun (clrOverrun),
    .count      (count),
    .full       (full),
    .overrun    (overrun),
    .errCount   (errCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rxByte = b;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    tick();
  endtask

  task automatic pop();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  task automatic err_pulse();
    rxErr = 1'b1;
    tick();
    rxErr = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstN = 1'b0; rxDone = 1'b0; rxErr = 1'b0; rxByte = '0;
    outReady = 1'b0; flush = 1'b0; clrOverrun = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(outValid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_errcount", 32'(errCount), 0);
    rstN = 1'b1;
    tick();

    // single byte, 1-cycle latency
    rxByte = 8'h56; rxDone = 1'b1;
    tick();
    chk("t1_valid", 32'(outValid), 1);
    chk("t1_byte", 32'(outByte), 32'h56);
    chk("t1_count", 32'(count), 1);
    rxDone = 1'b0;
    tick();
    pop();
    chk("t1_pop_count", 32'(count), 0);
    chk("t1_pop_valid", 32'(outValid), 0);

    // fill, overrun, drain, clear
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_full", 32'(full), 1);
    chk("t2_count", 32'(count), 16);
    push(8'hAA);
    chk("t2_overrun", 32'(overrun), 1);
    chk("t2_count_drop", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain_byte", 32'(outByte), 32'(i));
      pop();
    end
    chk("t2_empty", 32'(outValid), 0);
    chk("t2_overrun_held", 32'(overrun), 1);
    clrOverrun = 1'b1;
    tick();
    clrOverrun = 1'b0;
    chk("t2_clr_overrun", 32'(overrun), 0);

    // push+pop while full
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    chk("t3_full", 32'(full), 1);
    rxByte = 8'h77; rxDone = 1'b1; outReady = 1'b1;
    tick();
    rxDone = 1'b0; outReady = 1'b0;
    chk("t3_count", 32'(count), 16);
    chk("t3_overrun", 32'(overrun), 0);
    chk("t3_head", 32'(outByte), 32'h11);
    tick();
    for (int i = 1; i < 16; i++) begin
      chk("t3_drain_byte", 32'(outByte), 32'(8'h10 + i));
      pop();
    end
    chk("t3_last_byte", 32'(outByte), 32'h77);
    pop();
    chk("t3_empty", 32'(outValid), 0);

    // framing errors
    rxErr = 1'b1;
    tick();
    chk("t4_err1", 32'(errCount), 1);
    rxByte = 8'h99; rxDone = 1'b1;
    tick();
    chk("t4_nopush", 32'(count), 0);
    chk("t4_err_nodouble", 32'(errCount), 1);
    rxDone = 1'b0; rxErr = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) err_pulse();
    chk("t4_err101", 32'(errCount), 101);
    for (int i = 0; i < 200; i++) err_pulse();
    chk("t4_err_sat", 32'(errCount), 255);

    // rxDone held through reset release
    rstN = 1'b0; rxDone = 1'b1; rxByte = 8'h5A;
    tick();
    rstN = 1'b1;
    tick(); tick(); tick();
    chk("t5_nopush", 32'(count), 0);
    chk("t5_novalid", 32'(outValid), 0);
    rxDone = 1'b0;
    tick();
    rxByte = 8'h3C; rxDone = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rxDone = 1'b0;
    tick();
    chk("t5_once", 32'(count), 1);
    chk("t5_byte", 32'(outByte), 32'h3C);
    pop();
    chk("t5_empty", 32'(count), 0);

    // flush with concurrent push; overrun set wins over clear
    err_pulse();
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    rxByte = 8'hEF; rxDone = 1'b1; clrOverrun = 1'b1;
    tick();
    rxDone = 1'b0; clrOverrun = 1'b0;
    chk("t6_set_wins", 32'(overrun), 1);
    tick();
    for (int i = 0; i < 11; i++) pop();
    chk("t6_count5", 32'(count), 5);
    chk("t6_head", 32'(outByte), 32'h4B);
    flush = 1'b1; rxByte = 8'h55; rxDone = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_flush_count", 32'(count), 0);
    chk("t6_flush_valid", 32'(outValid), 0);
    chk("t6_flush_err", 32'(errCount), 1);
    chk("t6_flush_ovr", 32'(overrun), 1);
    rxDone = 1'b0;
    tick();
    chk("t6_after_flush", 32'(count), 0);

    // asynchronous reset mid-drain
    push(8'h01); push(8'h02); push(8'h03);
    pop();
    chk("t7_count", 32'(count), 2);
    #2;
    rstN = 1'b0;
    #1;
    chk("t7_async_count", 32'(count), 0);
    chk("t7_async_valid", 32'(outValid), 0);
    chk("t7_async_full", 32'(full), 0);
    chk("t7_async_ovr", 32'(overrun), 0);
    chk("t7_async_err", 32'(errCount), 0);
    tick();
    rstN = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer directly downstream of the Uart8 receiver. It edge-detects the receiver's rxDone/rxErr outputs and captures each good byte from the receiver's out bus into a first-word-fall-through FIFO. The consumer drains bytes through a valid/ready interface. The block keeps a sticky overrun flag and a saturating frame-error counter.

Parameters:
ADDR_WIDTH, 4, log2 of FIFO depth; DEPTH = 2**ADDR_WIDTH (default 16 entries)
ERR_WIDTH, 8, width of the frame-error counter

Ports:
clk  input  1  system clock, same domain as Uart8
rstN  input  1  asynchronous active-low reset
rxDone  input  1  Uart8 rxDone (level; a rising edge marks a completed frame)
rxErr  input  1  Uart8 rxErr (level; a rising edge marks a framing error)
rxByte  input  8  Uart8 out bus, stable while rxDone is high
outByte  output  8  head-of-FIFO byte, valid when outValid=1
outValid  output  1  FIFO non-empty
outReady  input  1  consumer accepts outByte when outValid&outReady at a clk edge
flush  input  1  synchronous clear of FIFO contents
clrOverrun  input  1  synchronous clear of the overrun flag
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
full  output  1  count==DEPTH
overrun  output  1  sticky: a good byte was dropped because the FIFO was full
errCount  output  ERR_WIDTH  number of framing errors, saturating

Behaviour:
- Reset (rstN=0, asynchronous): rdPtr=wrPtr=0, count=0, outValid=0, full=0, overrun=0, errCount=0. Edge-detect registers doneQ and errQ reset to 1, so a level already high at reset release is not treated as an event. Memory contents are not reset. outByte is don't-care while outValid=0.
- Events, evaluated combinationally from the current inputs and the registered previous values:
  - doneRise = rxDone & ~doneQ
  - errRise = rxErr & ~errQ
  - doneQ<=rxDone and errQ<=rxErr every cycle.
- Push request = doneRise & ~rxErr. On doneRise with rxErr=1 there is no push, and errCount increments once only if errRise is also true that cycle; no double count.
- errRise increments errCount by 1 and saturates at 2**ERR_WIDTH-1 (never wraps).
- Pop = outValid & outReady.
- Push with count<DEPTH: mem[wrPtr]<=rxByte, wrPtr wraps modulo DEPTH. The byte is visible on outByte/outValid right after the same clk edge when the FIFO was empty (1-cycle latency from rxDone sampled high).
- Push with count==DEPTH and no pop: byte dropped, overrun<=1, pointers and count unchanged.
- Push and pop in the same cycle:
  - Always accepted, including when full; count is unchanged.
  - When full, the popped slot is freed and the new byte is written to the old wrPtr position (equal to rdPtr); mem is written after the read, so outByte shows the next entry.
  - When empty, pop is impossible (outValid=0), so the cycle is push only.
- outByte = mem[rdPtr] (FWFT). It must remain stable while outValid=1 and outReady=0.
- count changes as follows: +1 on push only, -1 on pop only, unchanged on both or neither. full and outValid are derived from count.
- flush=1: pointers and count go to 0 at the next edge. Any push or pop in that cycle is ignored. overrun and errCount are not affected.
- clrOverrun=1: overrun<=0, unless a dropped push occurs in the same cycle, in which case overrun stays 1 (set wins).
- Pointer arithmetic is ADDR_WIDTH bits with natural wrap. count uses ADDR_WIDTH+1 bits so DEPTH is representable.
- Reset asserted mid-stream discards all contents immediately, with no glitch on outValid beyond going low.

Test Plan:
- Drive rxByte=0x56 and pulse rxDone 0->1 with rxErr=0 -> outValid=1 and outByte=0x56 on the next cycle, count=1; raising outReady for 1 cycle -> count=0, outValid=0.
- Push 16 bytes 0x00..0x0F with outReady=0 -> full=1, count=16. A 17th push of 0xAA -> overrun=1, count=16. Drain -> 0x00..0x0F in order, 0xAA absent. Pulse clrOverrun -> overrun=0.
- With FIFO full, assert outReady in the same cycle as a rxDone rise of 0x77 -> count stays 16, overrun=0, and 0x77 is read out last after the wrap of wrPtr/rdPtr.
- Raise rxErr, then rxDone while rxErr=1 -> no push, errCount=1. Apply 300 further rxErr rising edges -> errCount=255 (saturated).
- Hold rxDone=1 through the release of rstN -> no push after reset. A later 0->1 edge on rxDone pushes exactly once, even though rxDone is held high for 10 cycles.
- With 5 bytes queued, assert flush with a concurrent rxDone rise -> count=0 and outValid=0 next cycle, errCount and overrun unchanged. Asserting rstN=0 asynchronously mid-drain -> all outputs reach their reset values without waiting for a clk edge.
